// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the multiply/divide unit: the MD op encoding, the
//   default latencies and a small helper used to size the latency counter.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_OP_NONE  = 3'd0,
    MDU_OP_MULT  = 3'd1,
    MDU_OP_MULTU = 3'd2,
    MDU_OP_DIV   = 3'd3,
    MDU_OP_DIVU  = 3'd4,
    MDU_OP_MTHI  = 3'd5,
    MDU_OP_MTLO  = 3'd6,
    MDU_OP_RSVD  = 3'd7
  } mduOpT;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  function automatic int maxLat(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mul_div_unit_calc.sv
// mul_div_unit_calc
//   Purely combinational arithmetic core of the MD unit. Produces the 64-bit
//   {hi, lo} result for MULT/MULTU/DIV/DIVU, including the divide-by-zero and
//   signed-overflow results. Other op codes produce zero (unused by the top).
// Ports
//   op     in  3   MD op code (mduOpT encoding)
//   a      in  32  rs operand
//   b      in  32  rt operand
//   resHi  out 32  product high word / remainder
//   resLo  out 32  product low word / quotient
module mul_div_unit_calc
  import mul_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resHi,
  output logic [31:0] resLo
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic               divByZero;
  logic               divOverflow;

  assign prodS       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodU       = {32'd0, a} * {32'd0, b};
  assign divByZero   = (b == 32'd0);
  // The only signed quotient that does not fit in 32 bits.
  assign divOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    resHi = 32'd0;
    resLo = 32'd0;
    case (mduOpT'(op))
      MDU_OP_MULT: begin
        resHi = prodS[63:32];
        resLo = prodS[31:0];
      end
      MDU_OP_MULTU: begin
        resHi = prodU[63:32];
        resLo = prodU[31:0];
      end
      MDU_OP_DIV: begin
        if (divByZero) begin
          resHi = a;
          resLo = 32'hFFFF_FFFF;
        end else if (divOverflow) begin
          resHi = 32'd0;
          resLo = 32'h8000_0000;
        end else begin
          // SV signed division truncates toward zero; remainder follows a.
          resLo = $signed(a) / $signed(b);
          resHi = $signed(a) % $signed(b);
        end
      end
      MDU_OP_DIVU: begin
        if (divByZero) begin
          resHi = a;
          resLo = 32'hFFFF_FFFF;
        end else begin
          resLo = a / b;
          resHi = a % b;
        end
      end
      default: begin
        resHi = 32'd0;
        resLo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Execute-stage multiply/divide unit owning architectural HI/LO. MULT/MULTU
//   and DIV/DIVU compute their result at accept, park it in pending registers
//   and commit it to HI/LO after a fixed latency; MTHI/MTLO write directly.
//
//   state | meaning
//   IDLE  | cnt == 0, busy low, requests may be accepted
//   RUN   | cnt == N..1, result pending, requests ignored, HI/LO hold
//
// Ports
//   mdu_i_clk    in  1   clock
//   mdu_i_rst_n  in  1   async active-low reset
//   mdu_i_start  in  1   request valid this cycle
//   mdu_i_op     in  3   MD op code
//   mdu_i_a      in  32  rs operand
//   mdu_i_b      in  32  rt operand
//   mdu_o_hi     out 32  architectural HI
//   mdu_o_lo     out 32  architectural LO
//   mdu_o_busy   out 1   operation in flight
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input  logic        mdu_i_clk,
  input  logic        mdu_i_rst_n,
  input  logic        mdu_i_start,
  input  logic [2:0]  mdu_i_op,
  input  logic [31:0] mdu_i_a,
  input  logic [31:0] mdu_i_b,
  output logic [31:0] mdu_o_hi,
  output logic [31:0] mdu_o_lo,
  output logic        mdu_o_busy
);

  localparam int CNT_W = $clog2(maxLat(MULT_LAT, DIV_LAT) + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pendHi;
  logic [31:0]      pendLo;
  logic [31:0]      hiReg;
  logic [31:0]      loReg;
  logic [31:0]      resHi;
  logic [31:0]      resLo;

  mul_div_unit_calc uCalc (
    .op    (mdu_i_op),
    .a     (mdu_i_a),
    .b     (mdu_i_b),
    .resHi (resHi),
    .resLo (resLo)
  );

  always_ff @(posedge mdu_i_clk or negedge mdu_i_rst_n) begin
    if (!mdu_i_rst_n) begin
      cnt    <= '0;
      pendHi <= 32'd0;
      pendLo <= 32'd0;
      hiReg  <= 32'd0;
      loReg  <= 32'd0;
    end else if (cnt != '0) begin
      // Requests arriving while busy are dropped on purpose.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        hiReg <= pendHi;
        loReg <= pendLo;
      end
    end else if (mdu_i_start) begin
      case (mduOpT'(mdu_i_op))
        MDU_OP_MULT, MDU_OP_MULTU: begin
          pendHi <= resHi;
          pendLo <= resLo;
          cnt    <= CNT_W'(MULT_LAT);
        end
        MDU_OP_DIV, MDU_OP_DIVU: begin
          pendHi <= resHi;
          pendLo <= resLo;
          cnt    <= CNT_W'(DIV_LAT);
        end
        MDU_OP_MTHI: hiReg <= mdu_i_a;
        MDU_OP_MTLO: loReg <= mdu_i_a;
        default: ;
      endcase
    end
  end

  assign mdu_o_hi   = hiReg;
  assign mdu_o_lo   = loReg;
  assign mdu_o_busy = (cnt != '0);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  opIn = 3'd0;
  logic [31:0] aIn = 32'd0;
  logic [31:0] bIn = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .mdu_i_clk   (clk),
    .mdu_i_rst_n (rstN),
    .mdu_i_start (start),
    .mdu_i_op    (opIn),
    .mdu_i_a     (aIn),
    .mdu_i_b     (bIn),
    .mdu_o_hi    (hi),
    .mdu_o_lo    (lo),
    .mdu_o_busy  (busy)
  );

  // Reference model: plain 64-bit integer arithmetic, signed division done on
  // magnitudes and then re-signed.
  function automatic logic [63:0] refMd(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, qa, q, r;
    longint unsigned pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: begin pu = {32'd0, a}; pu = pu * {32'd0, b}; return pu; end
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        q  = ((sa < 0) != (sb < 0)) ? -qa : qa;
        r  = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(a % b), 32'(a / b)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one request and observes the busy window. Leaves time at the
  // negedge one cycle after the expected commit edge.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, output int busyCnt, output int holdCnt);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; opIn = op; aIn = a; bIn = b;
    @(posedge clk); #1;
    start = 1'b0; opIn = OP_NONE;
    busyCnt = 0; holdCnt = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if (hi === h0 && lo === l0) holdCnt++;
    end
    @(negedge clk);
  endtask

  task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk); start = 1'b1; opIn = OP_MTHI; aIn = h;
    @(negedge clk); opIn = OP_MTLO; aIn = l;
    @(negedge clk); start = 1'b0; opIn = OP_NONE;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
    rstN = 1'b1;
    writeHiLo(32'hAAAA_5555, 32'h1357_9BDF);
    @(posedge clk); #3;
    rstN = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_mult;
    logic [2:0]  dOp[2] = '{OP_MULT, OP_MULTU};
    logic [63:0] dExp[2] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA};
    int bc, hc;
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 2; i++) begin
      runOp(dOp[i], 32'hFFFF_FFFE, 32'd3, MULT_LAT, bc, hc);
      checks++;
      if ({hi, lo} !== dExp[i]) begin
        errors++;
        $display("FAIL mult_directed%0d: got %h_%h want %h", i, hi, lo, dExp[i]);
      end
      checks++;
      if (bc !== MULT_LAT || hc !== MULT_LAT || busy !== 1'b0) begin
        errors++;
        $display("FAIL mult_timing%0d: busyCycles=%0d holdCycles=%0d busyAfter=%b want %0d/%0d/0",
                 i, bc, hc, busy, MULT_LAT, MULT_LAT);
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      op = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      runOp(op, a, b, MULT_LAT, bc, hc);
      checks++;
      if ({hi, lo} !== refMd(op, a, b) || bc !== MULT_LAT) begin
        errors++;
        $display("FAIL mult_rand op=%0d a=%h b=%h: got %h_%h busy=%0d want %h busy=%0d",
                 op, a, b, hi, lo, bc, refMd(op, a, b), MULT_LAT);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  dOp[4]  = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] dA[4]   = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FF00};
    logic [31:0] dB[4]   = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] dExp[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0007_FFFF_FFFF,
                             64'h0000_0000_8000_0000, 64'hFFFF_FF00_FFFF_FFFF};
    int bc, hc;
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 4; i++) begin
      runOp(dOp[i], dA[i], dB[i], DIV_LAT, bc, hc);
      checks++;
      if ({hi, lo} !== dExp[i] || bc !== DIV_LAT || hc !== DIV_LAT || busy !== 1'b0) begin
        errors++;
        $display("FAIL div_directed%0d: got %h_%h busy=%0d hold=%0d want %h busy=%0d",
                 i, hi, lo, bc, hc, dExp[i], DIV_LAT);
      end
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (i == 7) b = 32'd0;
      if ($urandom_range(0, 1) == 0) b = {{20{b[31]}}, b[11:0]};
      op = (i % 2 == 0) ? OP_DIV : OP_DIVU;
      runOp(op, a, b, DIV_LAT, bc, hc);
      checks++;
      if ({hi, lo} !== refMd(op, a, b) || bc !== DIV_LAT) begin
        errors++;
        $display("FAIL div_rand op=%0d a=%h b=%h: got %h_%h busy=%0d want %h busy=%0d",
                 op, a, b, hi, lo, bc, refMd(op, a, b), DIV_LAT);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] l0;
    @(negedge clk);
    l0 = lo;
    start = 1'b1; opIn = OP_MTHI; aIn = 32'h1234_5678;
    @(posedge clk); #1;
    opIn = OP_MTLO; aIn = 32'h9ABC_DEF0;
    @(negedge clk);
    checks++;
    if (hi !== 32'h1234_5678 || lo !== l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b want 12345678/%h/0", hi, lo, busy, l0);
    end
    @(posedge clk); #1;
    start = 1'b0; opIn = OP_NONE;
    @(negedge clk);
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b want 12345678/9abcdef0/0", hi, lo, busy);
    end
  endtask

  task automatic test_noop;
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    start = 1'b1; opIn = OP_NONE; aIn = 32'hDEAD_BEEF; bIn = 32'd1;
    @(negedge clk); opIn = OP_RSVD;
    @(negedge clk); start = 1'b0;
    checks++;
    if (hi !== h0 || lo !== l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL noop: hi=%h lo=%h busy=%b want %h/%h/0", hi, lo, busy, h0, l0);
    end
  endtask

  task automatic test_ignore_while_busy;
    logic [31:0] h1, l1;
    int bc;
    bc = 0;
    @(negedge clk);
    start = 1'b1; opIn = OP_MULT; aIn = 32'h0001_0003; bIn = 32'hFFFF_0007;
    @(posedge clk); #1;
    start = 1'b0; opIn = OP_NONE;
    for (int i = 1; i <= MULT_LAT; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (i == 3) begin
        start = 1'b1; opIn = OP_DIV; aIn = 32'd100; bIn = 32'd7;
      end else begin
        start = 1'b0; opIn = OP_NONE;
      end
    end
    @(negedge clk);
    checks++;
    if ({hi, lo} !== refMd(OP_MULT, 32'h0001_0003, 32'hFFFF_0007) || bc !== MULT_LAT ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_commit: got %h_%h busy=%0d want %h busy=%0d",
               hi, lo, bc, refMd(OP_MULT, 32'h0001_0003, 32'hFFFF_0007), MULT_LAT);
    end
    h1 = hi; l1 = lo;
    repeat (DIV_LAT + 2) @(negedge clk);
    checks++;
    if (hi !== h1 || lo !== l1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_div: hi=%h lo=%h busy=%b want %h/%h/0", hi, lo, busy, h1, l1);
    end
  endtask

  task automatic test_reset_mid_div;
    writeHiLo(32'h0F0F_0F0F, 32'hF0F0_F0F0);
    start = 1'b1; opIn = OP_DIV; aIn = 32'd1000; bIn = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; opIn = OP_NONE;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL div_inflight: busy=%b hi=%h want 1/0f0f0f0f", busy, hi);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
    @(negedge clk); rstN = 1'b1;
    repeat (DIV_LAT + 4) @(negedge clk);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_commit: hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_noop();
    test_ignore_while_busy();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
